xf100_exu_disp: RTL and testbench
=================================

// Module: xf100_exu_disp
// PURPOSE
//  Dispatch/issue controller between xf100_exu_decode and the ALU. Holds one decoded
//  instruction in an output stage and keeps a 32-entry register scoreboard so no RAW/WAW
//  hazard reaches the ALU. Valid/ready toward both sides; writeback clears scoreboard bits.
//  Flush kills the held instruction. Non-ALU ops are dropped with an illegal pulse.
// PARAMETERS
//  INFO_W  11  width of alu_info bundle (= ALU_INFO_WIDTH)
//  XLEN    32  immediate width (= XF100_XLEN)
//  MAX_OUT 4   max outstanding rd writes in flight (1..31)
// PORTS
//  clk          in  1      clock, rising edge
//  rst_n        in  1      async active-low reset
//  flush        in  1      sync kill of the held instruction
//  i_valid      in  1      decode output valid
//  i_ready      out 1      dispatch can accept this cycle
//  i_alu_op     in  1      decoded op is an ALU op
//  i_alu_info   in  INFO_W one-hot ALU op
//  i_rs1_en/i_rs2_en/i_rd_en in 1   operand enables
//  i_rs1_idx/i_rs2_idx/i_rd_idx in 5 register indices
//  i_imm        in  XLEN   immediate
//  o_valid      out 1      instruction presented to ALU
//  o_ready      in  1      ALU accepts
//  o_alu_info/o_rs1_idx/o_rs2_idx/o_rd_idx/o_rd_en/o_imm out  registered copies of inputs
//  wb_valid     in  1      ALU writeback valid
//  wb_rd_idx    in  5      register written back
//  o_illegal    out 1      1-cycle pulse: non-ALU op dropped
//  o_stall_haz  out 1      i_valid blocked by hazard or MAX_OUT (combinational)
// BEHAVIOUR
//  Reset: o_valid=0, o_illegal=0, scoreboard sb[31:0]=0, cnt=0, payload regs=0.
//  wb_clr[k] = wb_valid & (wb_rd_idx==k) & sb[k] & (k!=0); sbe = sb & ~wb_clr (wb bypass).
//  haz = (i_rs1_en & sbe[i_rs1_idx]) | (i_rs2_en & sbe[i_rs2_idx]) | (i_rd_en & sbe[i_rd_idx]).
//  Index 0 is never set in sb, so x0 operands never hazard.
//  full = (cnt==MAX_OUT) & ~(wb_clr!=0) & i_rd_en & (i_rd_idx!=0).
//  i_ready = ~flush & (~o_valid | o_ready) & ~haz & ~full. i_ready is not a function of i_valid.
//  acc = i_valid & i_ready.
//  acc & i_alu_op: load payload regs, o_valid<=1 next cycle (1-cycle latency).
//    If i_rd_en & i_rd_idx!=0, set sb[i_rd_idx] and increment cnt.
//  acc & ~i_alu_op: nothing loaded or set; o_illegal<=1 for one cycle.
//    If o_valid & o_ready the same cycle, o_valid<=0.
//  o_valid & o_ready & ~acc-of-ALU-op: o_valid<=0 next cycle.
//  o_valid & ~o_ready: payload holds stable (no change while stalled).
//  wb: the sb bit clears and cnt decrements next cycle. A wb to a clear bit or to x0 is ignored.
//  Same-cycle set and clear of the same index cannot occur (WAW blocks it).
//    Set and clear of different indices in the same cycle leaves cnt unchanged.
//  flush: o_valid<=0. If the held instruction had o_rd_en & o_rd_idx!=0, clear its sb bit and
//    decrement cnt. If it is o_ready that same cycle, it counts as issued (no clear).
//    No accept happens in a flush cycle.
//  cnt never wraps; range 0..MAX_OUT. Reset mid-operation drops everything asynchronously.
// TESTING
//  1 add x5,x1,x2 then add x6,x5,x3, no wb -> 2nd stalls (o_stall_haz=1); wb x5 -> accepted same cycle.
//  2 rd=x0 op, then op reading x0 -> no sb set, no stall, cnt stays 0.
//  3 MAX_OUT=4: issue writes x1..x4, no wb -> 5th (x7) stalls; wb x2 that cycle -> accepted, cnt=4.
//  4 o_ready=0 for 3 cycles with o_valid=1 -> payload constant, i_ready=0; o_ready=1 -> next accepted.
//  5 flush with held x9 write, o_ready=0 -> o_valid=0, sb[9]=0, cnt-1; flush&o_ready -> sb[9] stays 1.
//  6 i_alu_op=0 accepted -> o_illegal=1 one cycle, o_valid unchanged; assert rst_n=0 mid-stall -> all zero.

Source files
------------

// File: rtl/xf100_exu_disp.sv
// Dispatch/issue stage between decode and the ALU: one-entry output
// register plus a 32-bit scoreboard that blocks RAW/WAW hazards.
// Ports: clk/rst_n/flush; i_* decode side (valid/ready); o_* ALU side
// (valid/ready + payload); wb_* writeback; o_illegal, o_stall_haz.
module xf100_exu_disp #(
  parameter int INFO_W  = 11,
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_alu_op,
  input  logic [INFO_W-1:0] i_alu_info,
  input  logic              i_rs1_en,
  input  logic              i_rs2_en,
  input  logic              i_rd_en,
  input  logic [4:0]        i_rs1_idx,
  input  logic [4:0]        i_rs2_idx,
  input  logic [4:0]        i_rd_idx,
  input  logic [XLEN-1:0]   i_imm,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [INFO_W-1:0] o_alu_info,
  output logic [4:0]        o_rs1_idx,
  output logic [4:0]        o_rs2_idx,
  output logic [4:0]        o_rd_idx,
  output logic              o_rd_en,
  output logic [XLEN-1:0]   o_imm,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd_idx,
  output logic              o_illegal,
  output logic              o_stall_haz
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic              o_valid_q, o_valid_d;
  logic              o_illegal_q, o_illegal_d;
  logic [31:0]       sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_en_q, rd_en_d;
  logic [XLEN-1:0]   imm_q, imm_d;

  logic        wb_hit, fl_hit, set_hit;
  logic [31:0] wb_clr, fl_clr, set_vec, sbe;
  logic        haz, full, rdy, acc, ld;

  always_comb begin
    wb_hit = wb_valid & (wb_rd_idx != 5'd0)
           & sb_q[wb_rd_idx];
    wb_clr = wb_hit ? (32'd1 << wb_rd_idx) : 32'd0;
    // writeback in the same cycle releases the hazard
    sbe = sb_q & ~wb_clr;
    haz = (i_rs1_en & sbe[i_rs1_idx])
        | (i_rs2_en & sbe[i_rs2_idx])
        | (i_rd_en  & sbe[i_rd_idx]);
    full = (cnt_q == CW'(MAX_OUT)) & ~wb_hit
         & i_rd_en & (i_rd_idx != 5'd0);
    rdy = ~flush & (~o_valid_q | o_ready)
        & ~haz & ~full;
    acc = i_valid & rdy;
    ld  = acc & i_alu_op;
    set_hit = ld & i_rd_en & (i_rd_idx != 5'd0);
    set_vec = set_hit ? (32'd1 << i_rd_idx) : 32'd0;
    // a flushed, never-issued write releases its scoreboard slot
    fl_hit = flush & o_valid_q & ~o_ready
           & rd_en_q & (rd_q != 5'd0);
    fl_clr = fl_hit ? (32'd1 << rd_q) : 32'd0;

    sb_d  = (sb_q & ~wb_clr & ~fl_clr) | set_vec;
    cnt_d = cnt_q + CW'(set_hit)
          - CW'(wb_hit) - CW'(fl_hit);

    o_illegal_d = acc & ~i_alu_op;

    o_valid_d = o_valid_q;
    if (flush)        o_valid_d = 1'b0;
    else if (ld)      o_valid_d = 1'b1;
    else if (o_ready) o_valid_d = 1'b0;

    info_d  = info_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd_en_d = rd_en_q;
    imm_d   = imm_q;
    if (ld) begin
      info_d  = i_alu_info;
      rs1_d   = i_rs1_idx;
      rs2_d   = i_rs2_idx;
      rd_d    = i_rd_idx;
      rd_en_d = i_rd_en;
      imm_d   = i_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q   <= 1'b0;
      o_illegal_q <= 1'b0;
      sb_q        <= '0;
      cnt_q       <= '0;
      info_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      imm_q       <= '0;
    end else begin
      o_valid_q   <= o_valid_d;
      o_illegal_q <= o_illegal_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      info_q      <= info_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rd_en_q     <= rd_en_d;
      imm_q       <= imm_d;
    end
  end

  assign i_ready     = rdy;
  assign o_stall_haz = i_valid & (haz | full);
  assign o_valid     = o_valid_q;
  assign o_illegal   = o_illegal_q;
  assign o_alu_info  = info_q;
  assign o_rs1_idx   = rs1_q;
  assign o_rs2_idx   = rs2_q;
  assign o_rd_idx    = rd_q;
  assign o_rd_en     = rd_en_q;
  assign o_imm       = imm_q;

endmodule

// File: tb/tb_xf100_exu_disp.sv
// Directed bench for xf100_exu_disp: hazard stall, x0, MAX_OUT,
// backpressure, flush, illegal op and async reset.
module tb_xf100_exu_disp;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        i_valid, i_ready, i_alu_op;
  logic [10:0] i_alu_info;
  logic        i_rs1_en, i_rs2_en, i_rd_en;
  logic [4:0]  i_rs1_idx, i_rs2_idx, i_rd_idx;
  logic [31:0] i_imm;
  logic        o_valid, o_ready;
  logic [10:0] o_alu_info;
  logic [4:0]  o_rs1_idx, o_rs2_idx, o_rd_idx;
  logic        o_rd_en;
  logic [31:0] o_imm;
  logic        wb_valid;
  logic [4:0]  wb_rd_idx;
  logic        o_illegal, o_stall_haz;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  xf100_exu_disp #(.INFO_W(11), .XLEN(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_alu_op(i_alu_op), .i_alu_info(i_alu_info),
    .i_rs1_en(i_rs1_en), .i_rs2_en(i_rs2_en),
    .i_rd_en(i_rd_en), .i_rs1_idx(i_rs1_idx),
    .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
    .i_imm(i_imm), .o_valid(o_valid), .o_ready(o_ready),
    .o_alu_info(o_alu_info), .o_rs1_idx(o_rs1_idx),
    .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx),
    .o_rd_en(o_rd_en), .o_imm(o_imm),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx),
    .o_illegal(o_illegal), .o_stall_haz(o_stall_haz)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_valid = 0; i_alu_op = 1; i_alu_info = 11'h001;
    i_rs1_en = 0; i_rs2_en = 0; i_rd_en = 0;
    i_rs1_idx = 0; i_rs2_idx = 0; i_rd_idx = 0;
    i_imm = 0; wb_valid = 0; wb_rd_idx = 0; flush = 0;
  endtask

  task automatic op(input logic r1e, input logic [4:0] r1,
                    input logic r2e, input logic [4:0] r2,
                    input logic rde, input logic [4:0] rd,
                    input logic [31:0] imm);
    i_valid = 1; i_alu_op = 1;
    i_rs1_en = r1e; i_rs1_idx = r1;
    i_rs2_en = r2e; i_rs2_idx = r2;
    i_rd_en = rde; i_rd_idx = rd; i_imm = imm;
  endtask

  task automatic wb(input logic [4:0] r);
    idle();
    wb_valid = 1; wb_rd_idx = r;
    step();
    wb_valid = 0;
  endtask

  initial begin
    idle();
    o_ready = 1;
    rst_n = 0;
    step(); step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_sb", dut.sb_q, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    chk("rst_imm", o_imm, 0);
    rst_n = 1;
    step();

    // 1: RAW stall released by same-cycle writeback
    op(1, 1, 1, 2, 1, 5, 32'h11);
    #1;
    chk("t1_rdy_a", i_ready, 1);
    chk("t1_stall_a", o_stall_haz, 0);
    step();
    chk("t1_ov_a", o_valid, 1);
    chk("t1_rd_a", o_rd_idx, 5);
    chk("t1_sb_a", dut.sb_q, 32'h20);
    chk("t1_cnt_a", dut.cnt_q, 1);
    op(1, 5, 1, 3, 1, 6, 32'h22);
    #1;
    chk("t1_stall_b", o_stall_haz, 1);
    chk("t1_rdy_b", i_ready, 0);
    step();
    chk("t1_ov_b", o_valid, 0);
    wb_valid = 1; wb_rd_idx = 5;
    #1;
    chk("t1_stall_c", o_stall_haz, 0);
    chk("t1_rdy_c", i_ready, 1);
    step();
    chk("t1_sb_c", dut.sb_q, 32'h40);
    chk("t1_cnt_c", dut.cnt_q, 1);
    chk("t1_rd_c", o_rd_idx, 6);
    chk("t1_imm_c", o_imm, 32'h22);
    wb(6);
    chk("t1_sb_d", dut.sb_q, 0);
    chk("t1_cnt_d", dut.cnt_q, 0);

    // 2: x0 destination / x0 sources
    op(1, 1, 1, 2, 1, 0, 32'h0);
    step();
    chk("t2_sb_a", dut.sb_q, 0);
    chk("t2_cnt_a", dut.cnt_q, 0);
    op(1, 0, 1, 0, 1, 0, 32'h0);
    #1;
    chk("t2_stall", o_stall_haz, 0);
    step();
    chk("t2_cnt_b", dut.cnt_q, 0);
    chk("t2_ov", o_valid, 1);
    idle();
    step();

    // 3: outstanding limit
    for (int r = 1; r <= 4; r++) begin
      op(0, 0, 0, 0, 1, 5'(r), 32'(r));
      step();
    end
    chk("t3_cnt_a", dut.cnt_q, 4);
    chk("t3_sb_a", dut.sb_q, 32'h1E);
    op(0, 0, 0, 0, 1, 7, 32'h7);
    #1;
    chk("t3_stall", o_stall_haz, 1);
    chk("t3_rdy_a", i_ready, 0);
    wb_valid = 1; wb_rd_idx = 2;
    #1;
    chk("t3_rdy_b", i_ready, 1);
    step();
    chk("t3_cnt_b", dut.cnt_q, 4);
    chk("t3_sb_b", dut.sb_q, 32'h9A);
    wb(1); wb(3); wb(4); wb(7);
    chk("t3_cnt_c", dut.cnt_q, 0);
    chk("t3_sb_c", dut.sb_q, 0);

    // 4: backpressure holds payload
    o_ready = 0;
    i_alu_info = 11'h004;
    op(0, 0, 0, 0, 1, 10, 32'hABCD);
    step();
    chk("t4_ov_a", o_valid, 1);
    op(0, 0, 0, 0, 1, 11, 32'h1234);
    i_alu_info = 11'h010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_rdy_hold", i_ready, 0);
      chk("t4_stall_hold", o_stall_haz, 0);
      step();
      chk("t4_imm_hold", o_imm, 32'hABCD);
      chk("t4_info_hold", o_alu_info, 11'h004);
      chk("t4_rd_hold", o_rd_idx, 10);
      chk("t4_ov_hold", o_valid, 1);
    end
    o_ready = 1;
    #1;
    chk("t4_rdy_b", i_ready, 1);
    step();
    chk("t4_imm_b", o_imm, 32'h1234);
    chk("t4_rd_b", o_rd_idx, 11);
    chk("t4_cnt_b", dut.cnt_q, 2);
    idle();
    step();
    chk("t4_ov_c", o_valid, 0);
    wb(10); wb(11);
    chk("t4_cnt_c", dut.cnt_q, 0);

    // 5: flush of a held write
    o_ready = 0;
    op(0, 0, 0, 0, 1, 9, 32'h9);
    step();
    chk("t5_sb_a", dut.sb_q, 32'h200);
    idle();
    flush = 1;
    op(0, 0, 0, 0, 1, 12, 32'hC);
    #1;
    chk("t5_rdy_fl", i_ready, 0);
    step();
    idle();
    chk("t5_ov_b", o_valid, 0);
    chk("t5_sb_b", dut.sb_q, 0);
    chk("t5_cnt_b", dut.cnt_q, 0);
    op(0, 0, 0, 0, 1, 9, 32'h9);
    step();
    idle();
    flush = 1; o_ready = 1;
    step();
    flush = 0;
    chk("t5_ov_c", o_valid, 0);
    chk("t5_sb_c", dut.sb_q, 32'h200);
    chk("t5_cnt_c", dut.cnt_q, 1);
    wb(9);
    chk("t5_cnt_d", dut.cnt_q, 0);

    // 6: illegal op, then async reset mid-stall
    op(0, 0, 0, 0, 1, 13, 32'hD);
    i_alu_op = 0;
    #1;
    chk("t6_rdy", i_ready, 1);
    step();
    idle();
    chk("t6_ill_a", o_illegal, 1);
    chk("t6_ov_a", o_valid, 0);
    chk("t6_sb_a", dut.sb_q, 0);
    step();
    chk("t6_ill_b", o_illegal, 0);
    o_ready = 0;
    op(0, 0, 0, 0, 1, 14, 32'hE);
    step();
    op(1, 14, 0, 0, 1, 15, 32'hF);
    #1;
    chk("t6_stall", o_stall_haz, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_ov", o_valid, 0);
    chk("t6_rst_sb", dut.sb_q, 0);
    chk("t6_rst_cnt", dut.cnt_q, 0);
    chk("t6_rst_rd", o_rd_idx, 0);
    chk("t6_rst_imm", o_imm, 0);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
